// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder.
package spi_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W);

    localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'hFF;
    localparam logic [CNT_W-1:0]  LAST_BIT          = CNT_W'(BYTE_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/spi_responder_sync.sv
// Multi-flop synchronizer with a history flop providing single-cycle edge strobes.
module spi_responder_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  q & ~hist_q;
    assign fall = ~q &  hist_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave: byte-wide tx holding register, rx output register, sticky error flags.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ssn_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oeb_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              overrun_o,
    output logic              underrun_o,
    input  logic              clr_i
);

    logic ssn_q, ssn_rise, ssn_fall;
    logic sclk_unused, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;

    spi_responder_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
        .clk(wb_clk_i), .rst(wb_rst_i), .d(ssn_i),
        .q(ssn_q), .rise(ssn_rise), .fall(ssn_fall)
    );
    spi_responder_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(wb_clk_i), .rst(wb_rst_i), .d(sclk_i),
        .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_responder_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(wb_clk_i), .rst(wb_rst_i), .d(mosi_i),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // The synchronizer resets to "deselected", so a select held low across reset
    // would look like a fresh falling edge. Arm only after a genuine high is seen.
    logic [SYNC_STAGES:0] vld_pipe;
    logic                 armed_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vld_pipe <= '0;
            armed_q  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            if (vld_pipe[SYNC_STAGES] && ssn_q)
                armed_q <= 1'b1;
        end
    end

    state_t state_q, state_d;
    logic   start, abort;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: if (ssn_fall && armed_q) begin
                state_d = SHIFT;
                start   = 1'b1;
            end
            SHIFT: if (ssn_rise) begin
                state_d = IDLE;
                abort   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_W-1:0] tx_sr_q, rx_sr_q, hold_q, rx_data_q;
    logic              hold_full_q, hold_full_d, tx_ready_q, rx_valid_q;
    logic              overrun_q, underrun_q;
    logic              shifting, bit_rise, bit_fall, load, rx_done, tx_accept;

    // A deselect in the same cycle as an sclk edge wins: the edge is ignored.
    assign shifting    = (state_q == SHIFT) && !ssn_rise;
    assign bit_rise    = shifting && sclk_rise;
    assign bit_fall    = shifting && sclk_fall;
    assign load        = start || (bit_fall && bit_cnt_q == '0);
    assign rx_done     = bit_rise && bit_cnt_q == LAST_BIT;
    assign tx_accept   = tx_valid_i && tx_ready_q;
    assign hold_full_d = tx_accept || (hold_full_q && !load);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_ready_q  <= 1'b1;
            tx_sr_q     <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            tx_ready_q  <= !hold_full_d;
            if (tx_accept)
                hold_q <= tx_data_i;
            if (load)
                tx_sr_q <= hold_full_q ? hold_q : IDLE_BYTE;
            else if (bit_fall)
                tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (start || abort) begin
                bit_cnt_q <= '0;
                rx_sr_q   <= '0;
            end else if (bit_rise) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                rx_sr_q   <= {rx_sr_q[BYTE_W-2:0], mosi_q};
            end
            if (rx_done && (!rx_valid_q || rx_ready_i)) begin
                rx_data_q  <= {rx_sr_q[BYTE_W-2:0], mosi_q};
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= (overrun_q && !clr_i) || (rx_done && rx_valid_q && !rx_ready_i);
            underrun_q <= (underrun_q && !clr_i) || (load && !hold_full_q);
        end
    end

    assign miso_o     = (state_q == SHIFT) && tx_sr_q[BYTE_W-1];
    assign miso_oeb_o = (state_q != SHIFT);
    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign overrun_o  = overrun_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Randomized + directed bench for spi_responder against a byte-level reference model.
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ssn = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, rx_ready = 1'b0, clr = 1'b0;
    logic       miso_o, miso_oeb_o, tx_ready_o, rx_valid_o, overrun_o, underrun_o;
    logic [7:0] rx_data_o;

    always #5 clk = ~clk;

    spi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .ssn_i(ssn), .sclk_i(sclk), .mosi_i(mosi),
        .miso_o(miso_o), .miso_oeb_o(miso_oeb_o),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .overrun_o(overrun_o), .underrun_o(underrun_o), .clr_i(clr)
    );

    int total = 0, bad = 0;

    // Reference model: holding register, byte currently on miso, rx pending, flags.
    bit         m_full = 0, m_pend = 0, m_ovr = 0, m_unf = 0;
    logic [7:0] m_hold = 8'h00, m_cur = 8'h00;
    logic [7:0] exp_q[$], got_q[$];
    bit         saw_valid = 0;

    always @(negedge clk) begin
        #1;
        if (rx_valid_o) saw_valid = 1;
        if (rx_valid_o && rx_ready) got_q.push_back(rx_data_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_load();
        if (m_full) begin m_cur = m_hold; m_full = 0; end
        else begin m_cur = 8'hFF; m_unf = 1; end
    endtask

    task automatic m_rx(logic [7:0] b);
        if (m_pend) m_ovr = 1;
        else begin exp_q.push_back(b); m_pend = 1; end
    endtask

    task automatic tx_write(logic [7:0] d);
        chk("tx_ready", 8'(tx_ready_o), 8'(!m_full));
        if (!m_full) begin
            tx_data = d; tx_valid = 1; tick(1); tx_valid = 0;
            m_hold = d; m_full = 1;
            tick(1);
            chk("tx_ready_full", 8'(tx_ready_o), 8'd0);
        end
    endtask

    task automatic clr_pulse();
        clr = 1; tick(1); clr = 0; tick(1);
        m_ovr = 0; m_unf = 0;
    endtask

    task automatic frame_begin();
        ssn = 0; tick(8);
        m_load();
    endtask

    // Deselect while sclk is still high so no trailing byte-boundary fall occurs.
    task automatic frame_end();
        ssn = 1; tick(8);
        sclk = 0; tick(8);
        chk("oeb_idle", 8'(miso_oeb_o), 8'd1);
        chk("miso_idle", 8'(miso_o), 8'd0);
    endtask

    task automatic spi_byte(logic [7:0] mo, int nbits, bit first, bit wr_mid,
                            logic [7:0] wd, bit rdy_end);
        logic [7:0] sh;
        logic [7:0] mi;
        sh = mo;
        mi = 8'h00;
        if (!first) m_load();
        for (int i = 0; i < nbits; i++) begin
            if (!(first && i == 0)) sclk = 0;
            mosi = sh[7];
            sh   = sh << 1;
            tick(8);
            mi = {mi[6:0], miso_o};
            if (wr_mid && i == 3) tx_write(wd);
            sclk = 1;
            if (rdy_end && i == 7) begin tick(2); rx_ready = 1; tick(6); end
            else tick(8);
        end
        if (nbits == 8) begin
            chk("miso_byte", mi, m_cur);
            if (rdy_end) m_pend = 0;
            m_rx(mo);
        end
    endtask

    task automatic rx_drain();
        int n;
        n = 0;
        if (m_pend) begin
            while (!rx_valid_o && n < 50) begin tick(1); n++; end
            chk("rx_valid", 8'(rx_valid_o), 8'd1);
            rx_ready = 1; tick(1); rx_ready = 0; tick(1);
            m_pend = 0;
        end
    endtask

    task automatic cmp_rx(string tag);
        chk({tag, "_cnt"}, 8'(got_q.size()), 8'(exp_q.size()));
        foreach (exp_q[i])
            if (i < got_q.size()) chk(tag, got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic cmp_flags(string tag);
        chk({tag, "_ovr"}, 8'(overrun_o), 8'(m_ovr));
        chk({tag, "_unf"}, 8'(underrun_o), 8'(m_unf));
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_tx_ready"}, 8'(tx_ready_o), 8'd1);
        chk({tag, "_rx_valid"}, 8'(rx_valid_o), 8'd0);
        chk({tag, "_rx_data"}, rx_data_o, 8'h00);
        chk({tag, "_miso"}, 8'(miso_o), 8'd0);
        chk({tag, "_oeb"}, 8'(miso_oeb_o), 8'd1);
        chk({tag, "_ovr"}, 8'(overrun_o), 8'd0);
        chk({tag, "_unf"}, 8'(underrun_o), 8'd0);
    endtask

    int nb;
    bit wr;

    initial begin
        tick(3);
        chk_reset_vals("reset");
        rst = 0;
        tick(10);

        // Held byte goes out on miso; received byte reported; no flags.
        tx_write(8'hA5);
        frame_begin();
        spi_byte(8'h3C, 8, 1, 0, 8'h00, 0);
        frame_end();
        chk("a5_rx_valid", 8'(rx_valid_o), 8'd1);
        chk("a5_rx_data", rx_data_o, 8'h3C);
        cmp_flags("a5");
        rx_drain();
        cmp_rx("a5_rx");

        // Empty holding register: idle byte and underrun, then clear.
        frame_begin();
        spi_byte(8'h81, 8, 1, 0, 8'h00, 0);
        frame_end();
        rx_drain();
        cmp_rx("unf_rx");
        cmp_flags("unf");
        clr_pulse();
        cmp_flags("unf_clr");

        // Two bytes without consumption: first kept, overrun set.
        frame_begin();
        spi_byte(8'h11, 8, 1, 0, 8'h00, 0);
        spi_byte(8'h22, 8, 0, 0, 8'h00, 0);
        frame_end();
        chk("ovr_rx_data", rx_data_o, 8'h11);
        cmp_flags("ovr");
        rx_drain();
        cmp_rx("ovr_rx");
        clr_pulse();

        // Aborted 5-bit frame then a full frame: only the full byte is reported.
        tx_write(8'h96);
        frame_begin();
        spi_byte(8'hC7, 5, 1, 0, 8'h00, 0);
        frame_end();
        chk("abort_no_valid", 8'(rx_valid_o), 8'd0);
        frame_begin();
        spi_byte(8'h7E, 8, 1, 0, 8'h00, 0);
        frame_end();
        rx_drain();
        cmp_rx("abort_rx");
        cmp_flags("abort");
        clr_pulse();

        // Second completion coincides with consumption of the first.
        tx_write(8'h0F);
        frame_begin();
        spi_byte(8'h5A, 8, 1, 0, 8'h00, 0);
        spi_byte(8'hC3, 8, 0, 0, 8'h00, 1);
        frame_end();
        rx_ready = 0;
        m_pend = 0;
        tick(2);
        cmp_rx("same_cyc_rx");
        cmp_flags("same_cyc");
        clr_pulse();

        // Reset in the middle of a frame.
        tx_write(8'h3C);
        frame_begin();
        spi_byte(8'hB7, 4, 1, 0, 8'h00, 0);
        rst = 1; saw_valid = 0;
        tick(1);
        chk_reset_vals("midrst");
        rst = 0;
        m_full = 0; m_pend = 0; m_ovr = 0; m_unf = 0;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++) begin
            sclk = 0; tick(8); sclk = 1; tick(8);
        end
        frame_end();
        chk("midrst_no_valid", 8'(saw_valid), 8'd0);
        cmp_flags("midrst");
        tick(4);
        tx_write(8'h5C);
        frame_begin();
        spi_byte(8'hE1, 8, 1, 0, 8'h00, 0);
        frame_end();
        rx_drain();
        cmp_rx("postrst_rx");
        cmp_flags("postrst");

        // Random frames of 1..3 bytes with optional mid-byte refills.
        for (int f = 0; f < 25; f++) begin
            nb = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            frame_begin();
            for (int k = 0; k < nb; k++) begin
                wr = (k < nb - 1) && !m_full && ($urandom_range(0, 1) == 1);
                spi_byte(8'($urandom), 8, k == 0, wr, 8'($urandom), 0);
            end
            frame_end();
            cmp_flags("rand");
            rx_drain();
            cmp_rx("rand_rx");
            if ($urandom_range(0, 2) == 0) begin
                clr_pulse();
                cmp_flags("rand_clr");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
